// File: rtl/pipe_skp_scheduler.sv
// PIPE x1 TX SKP scheduler: forwards upstream symbols and inserts COM + SkpLen x SKP
// every SkpInterval symbols at packet boundaries. Define PIPE_SKP_STATS_EN for SkpCount.
module pipe_skp_scheduler #(
    parameter int unsigned SkpInterval = 1180,
    parameter int unsigned SkpLen      = 3
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  InData,
    input  logic        InDataK,
    input  logic        InValid,
    input  logic        InEop,
    output logic        InReady,
    output logic [7:0]  TxData,
    output logic        TxDataK,
    output logic [1:0]  SkpPending
`ifdef PIPE_SKP_STATS_EN
    ,
    output logic [15:0] SkpCount
`endif
);

    localparam logic [7:0]  SymCom  = 8'hBC;
    localparam logic [7:0]  SymSkp  = 8'h1C;
    localparam logic [7:0]  SymIdle = 8'h00;
    localparam logic [11:0] CntLast = 12'(SkpInterval - 1);
    localparam logic [2:0]  SkpLast = 3'(SkpLen - 1);

    typedef enum logic [1:0] {IDLE, DATA, COM, SKP} stateT;

    stateT       state;
    logic [11:0] symCnt;
    logic [1:0]  pending;
    logic        inPacket;
    logic [2:0]  skpLeft;

    logic        wrap;
    logic        owed;
    logic        streamSlot;
    logic        transfer;
    logic        grant;
    logic [1:0]  pendingNext;

    always_comb begin
        wrap       = enable && (symCnt == CntLast);
        owed       = (pending != 2'd0) && !inPacket;
        streamSlot = (state == IDLE) || (state == DATA);
        InReady    = !reset && enable && streamSlot && !owed;
        transfer   = InValid && InReady;
        // A wrap seen in an idle slot is served at once; the last SKP slot also
        // decides, so several owed ordered sets go out back-to-back.
        grant      = enable && !inPacket && !transfer
                     && (streamSlot || (state == SKP && skpLeft == '0))
                     && ((pending != 2'd0) || wrap);
        pendingNext = pending;
        if (wrap && !grant && pending != 2'd3) begin
            pendingNext = pending + 2'd1;
        end else if (grant && !wrap) begin
            pendingNext = pending - 2'd1;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            TxData   <= SymIdle;
            TxDataK  <= 1'b0;
            symCnt   <= '0;
            pending  <= '0;
            inPacket <= 1'b0;
            skpLeft  <= '0;
        end else begin
            pending <= pendingNext;
            if (enable) begin
                symCnt <= wrap ? '0 : symCnt + 12'd1;
            end
            if (transfer) begin
                inPacket <= !InEop;
            end

            if (transfer) begin
                state   <= DATA;
                TxData  <= InData;
                TxDataK <= InDataK;
            end else if (grant) begin
                state   <= COM;
                TxData  <= SymCom;
                TxDataK <= 1'b1;
            end else begin
                case (state)
                    COM: begin
                        state   <= SKP;
                        TxData  <= SymSkp;
                        TxDataK <= 1'b1;
                        skpLeft <= SkpLast;
                    end
                    SKP: begin
                        if (skpLeft != '0) begin
                            TxData  <= SymSkp;
                            TxDataK <= 1'b1;
                            skpLeft <= skpLeft - 3'd1;
                        end else begin
                            state   <= IDLE;
                            TxData  <= SymIdle;
                            TxDataK <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        TxData  <= SymIdle;
                        TxDataK <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SkpPending = pending;

`ifdef PIPE_SKP_STATS_EN
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            SkpCount <= '0;
        end else if (grant) begin
            SkpCount <= SkpCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skp_scheduler.sv
// Directed scoreboard bench for pipe_skp_scheduler (SkpInterval=16, SkpLen=3).
// Expected symbols are queued when stimulus is driven and compared after each edge.
module tb_pipe_skp_scheduler;

    logic        pclk    = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic [7:0]  InData  = 8'h00;
    logic        InDataK = 1'b0;
    logic        InValid = 1'b0;
    logic        InEop   = 1'b0;
    logic        InReady;
    logic [7:0]  TxData;
    logic        TxDataK;
    logic [1:0]  SkpPending;
`ifdef PIPE_SKP_STATS_EN
    logic [15:0] SkpCount;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       k;
        string      tag;
    } expSymT;

    expSymT expQ[$];

    pipe_skp_scheduler #(
        .SkpInterval(16),
        .SkpLen     (3)
    ) dut (
        .pclk      (pclk),
        .reset     (reset),
        .enable    (enable),
        .InData    (InData),
        .InDataK   (InDataK),
        .InValid   (InValid),
        .InEop     (InEop),
        .InReady   (InReady),
        .TxData    (TxData),
        .TxDataK   (TxDataK),
        .SkpPending(SkpPending)
`ifdef PIPE_SKP_STATS_EN
        ,
        .SkpCount  (SkpCount)
`endif
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, required self-termination");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic v, input logic [7:0] d,
                         input logic k, input logic eop);
        enable  = en;
        InValid = v;
        InData  = d;
        InDataK = k;
        InEop   = eop;
    endtask

    task automatic pushSym(input logic [7:0] d, input logic k, input string tag);
        expSymT e;
        e.data = d;
        e.k    = k;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    task automatic tick();
        expSymT e;
        @(posedge pclk);
        #1;
        if (expQ.size() == 0) begin
            check("scoreboard queue size", 16'(expQ.size()), 16'd1);
        end else begin
            e = expQ.pop_front();
            check({e.tag, " TxData"}, 16'(TxData), 16'(e.data));
            check({e.tag, " TxDataK"}, 16'(TxDataK), 16'(e.k));
        end
    endtask

    function automatic logic [8:0] idleSym(input int n);
        if (n % 16 == 0) return {1'b1, 8'hBC};
        if (n > 16 && n % 16 <= 3) return {1'b1, 8'h1C};
        return 9'h000;
    endfunction

    // Idle line with enable high: n counts edges since reset release.
    task automatic runIdle(input string tag, input int last);
        logic [8:0] s;
        for (int n = 1; n <= last; n++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            #1;
            check($sformatf("%s e%0d InReady", tag, n), 16'(InReady),
                  16'(!(n > 16 && n % 16 >= 1 && n % 16 <= 4)));
            s = idleSym(n);
            pushSym(s[7:0], s[8], $sformatf("%s e%0d", tag, n));
            tick();
            if (n == 16) check({tag, " pending after idle COM"}, 16'(SkpPending), 16'd0);
        end
    endtask

    task automatic doReset(input string tag);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge pclk);
        #2;
        reset = 1'b1;
        #1;
        check({tag, " reset TxData"}, 16'(TxData), 16'h00);
        check({tag, " reset TxDataK"}, 16'(TxDataK), 16'd0);
        check({tag, " reset InReady"}, 16'(InReady), 16'd0);
        check({tag, " reset SkpPending"}, 16'(SkpPending), 16'd0);
`ifdef PIPE_SKP_STATS_EN
        check({tag, " reset SkpCount"}, SkpCount, 16'd0);
`endif
        @(posedge pclk);
        #1;
        reset = 1'b0;
        expQ.delete();
    endtask

    initial begin
        logic [7:0] d;

        // Idle line: 15 idle symbols, COM, 3 SKP, period 16
        doReset("S1");
        runIdle("S1", 35);

        // 20-symbol packet from edge 10; wrap inside packet defers COM to after EOP
        doReset("S2");
        for (int n = 1; n <= 38; n++) begin
            if (n >= 10 && n <= 29) begin
                d = (n == 10) ? 8'hFB : 8'(n + 64);
                drive(1'b1, 1'b1, d, n == 10, n == 29);
                #1;
                check($sformatf("S2 e%0d InReady in packet", n), 16'(InReady), 16'd1);
                pushSym(d, n == 10, $sformatf("S2 e%0d", n));
            end else begin
                drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
                #1;
                if (n == 30) check("S2 InReady while owed", 16'(InReady), 16'd0);
                if (n == 30 || n == 34)      pushSym(8'hBC, 1'b1, $sformatf("S2 e%0d", n));
                else if (n >= 31 && n <= 37) pushSym(8'h1C, 1'b1, $sformatf("S2 e%0d", n));
                else                         pushSym(8'h00, 1'b0, $sformatf("S2 e%0d", n));
            end
            tick();
            if (n == 16) check("S2 pending inside packet", 16'(SkpPending), 16'd1);
            if (n == 30) check("S2 pending after COM", 16'(SkpPending), 16'd0);
            if (n == 32) check("S2 pending after 2nd wrap", 16'(SkpPending), 16'd1);
            if (n == 34) check("S2 pending after 2nd COM", 16'(SkpPending), 16'd0);
        end

        // 40-cycle packet collects two owed sets, served back-to-back after EOP
        doReset("S3");
        for (int n = 1; n <= 53; n++) begin
            if (n <= 40) begin
                d = (n == 1) ? 8'hFB : 8'(n + 64);
                drive(1'b1, 1'b1, d, n == 1, n == 40);
                #1;
                check($sformatf("S3 e%0d InReady in packet", n), 16'(InReady), 16'd1);
                pushSym(d, n == 1, $sformatf("S3 e%0d", n));
            end else begin
                drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
                #1;
                if (n == 41) check("S3 InReady while owed", 16'(InReady), 16'd0);
                if (n == 41 || n == 45 || n == 49) pushSym(8'hBC, 1'b1, $sformatf("S3 e%0d", n));
                else if (n <= 52)                  pushSym(8'h1C, 1'b1, $sformatf("S3 e%0d", n));
                else                               pushSym(8'h00, 1'b0, $sformatf("S3 e%0d", n));
            end
            tick();
            if (n == 16) check("S3 pending e16", 16'(SkpPending), 16'd1);
            if (n == 32) check("S3 pending e32", 16'(SkpPending), 16'd2);
            if (n == 40) check("S3 pending at EOP", 16'(SkpPending), 16'd2);
            if (n == 41) check("S3 pending after COM1", 16'(SkpPending), 16'd1);
            if (n == 45) check("S3 pending after COM2", 16'(SkpPending), 16'd0);
            if (n == 48) check("S3 pending e48 wrap", 16'(SkpPending), 16'd1);
            if (n == 49) check("S3 pending after COM3", 16'(SkpPending), 16'd0);
        end

        // Reset on the 2nd SKP symbol abandons the sequence; counting restarts
        doReset("S4");
        runIdle("S4a", 18);
        reset = 1'b1;
        #1;
        check("S4 mid-SKP reset TxData", 16'(TxData), 16'h00);
        check("S4 mid-SKP reset TxDataK", 16'(TxDataK), 16'd0);
        check("S4 mid-SKP reset InReady", 16'(InReady), 16'd0);
        check("S4 mid-SKP reset SkpPending", 16'(SkpPending), 16'd0);
        @(posedge pclk);
        #1;
        reset = 1'b0;
        expQ.delete();
        runIdle("S4b", 17);

        // EOP in the wrap cycle: COM on the very next symbol
        doReset("S5a");
        for (int n = 1; n <= 21; n++) begin
            if (n >= 10 && n <= 16) begin
                d = (n == 10) ? 8'hFB : 8'(n + 64);
                drive(1'b1, 1'b1, d, n == 10, n == 16);
                #1;
                check($sformatf("S5a e%0d InReady", n), 16'(InReady), 16'd1);
                pushSym(d, n == 10, $sformatf("S5a e%0d", n));
            end else begin
                drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
                #1;
                if (n == 17)                 pushSym(8'hBC, 1'b1, $sformatf("S5a e%0d", n));
                else if (n >= 18 && n <= 20) pushSym(8'h1C, 1'b1, $sformatf("S5a e%0d", n));
                else                         pushSym(8'h00, 1'b0, $sformatf("S5a e%0d", n));
            end
            tick();
            if (n == 16) check("S5a pending at EOP wrap", 16'(SkpPending), 16'd1);
            if (n == 17) check("S5a pending after COM", 16'(SkpPending), 16'd0);
        end

        // Same, but enable dropped for 50 cycles with one set owed
        doReset("S5b");
        for (int n = 1; n <= 82; n++) begin
            if (n >= 10 && n <= 16) begin
                d = (n == 10) ? 8'hFB : 8'(n + 64);
                drive(1'b1, 1'b1, d, n == 10, n == 16);
                #1;
                pushSym(d, n == 10, $sformatf("S5b e%0d", n));
            end else if (n >= 17 && n <= 66) begin
                drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
                #1;
                check($sformatf("S5b e%0d InReady disabled", n), 16'(InReady), 16'd0);
                pushSym(8'h00, 1'b0, $sformatf("S5b e%0d", n));
            end else begin
                drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
                #1;
                if (n == 67) check("S5b InReady on re-enable", 16'(InReady), 16'd0);
                if (n == 67 || n == 82)      pushSym(8'hBC, 1'b1, $sformatf("S5b e%0d", n));
                else if (n >= 68 && n <= 70) pushSym(8'h1C, 1'b1, $sformatf("S5b e%0d", n));
                else                         pushSym(8'h00, 1'b0, $sformatf("S5b e%0d", n));
            end
            tick();
            if (n == 16) check("S5b pending at EOP wrap", 16'(SkpPending), 16'd1);
            if (n == 66) check("S5b pending held while disabled", 16'(SkpPending), 16'd1);
            if (n == 67) check("S5b pending after COM", 16'(SkpPending), 16'd0);
            if (n == 82) check("S5b pending after idle COM", 16'(SkpPending), 16'd0);
        end

`ifdef PIPE_SKP_STATS_EN
        doReset("S6");
        runIdle("S6", 80);
        check("S6 SkpCount after 5 COMs", SkpCount, 16'd5);
        doReset("S6 post");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skp_scheduler.md
PIPE_SKP_SCHEDULER -- requirements
Module: pipe_skp_scheduler

Interface
REQ-001 SHALL have parameter SkpInterval, default 1180, giving symbols transmitted between SKP ordered-set requests (legal range 4..4095).
REQ-002 SHALL have parameter SkpLen, default 3, giving SKP symbols following each COM (legal range 1..5).
REQ-003 SHALL have port pclk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1; when 1, symbol counting and SKP insertion are active.
REQ-006 SHALL have port InData, input, 8, upstream symbol byte.
REQ-007 SHALL have port InDataK, input, 1, upstream K-code flag.
REQ-008 SHALL have port InValid, input, 1, upstream symbol valid.
REQ-009 SHALL have port InEop, input, 1, qualifies the last symbol of a packet or ordered set.
REQ-010 SHALL have port InReady, output, 1; a symbol transfers when InValid and InReady are both 1.
REQ-011 SHALL have port TxData, output, 8, lane symbol to the PIPE x1 TX interface.
REQ-012 SHALL have port TxDataK, output, 1, lane K flag.
REQ-013 SHALL have port SkpPending, output, 2, count of owed SKP ordered sets.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, COM, SKP; TxData/TxDataK registered, one-cycle latency from transfer to output.
REQ-015 IDLE/DATA: accepted symbol drives TxData/TxDataK next cycle; no transfer -> logical idle 8'h00, K=0.
REQ-016 Internal in_packet flag: set on a transfer with InEop=0; cleared on a transfer with InEop=1.
REQ-017 12-bit symbol counter increments every cycle while enable=1, including idle, COM and SKP symbols; on reaching SkpInterval-1 it wraps to 0 and SkpPending increments, saturating at 3.
REQ-018 InReady = enable AND state in {IDLE, DATA} AND NOT (SkpPending!=0 AND in_packet=0).
REQ-019 When SkpPending!=0 and in_packet=0 in IDLE/DATA, next output is COM (8'hBC, K=1); state goes to COM.
REQ-020 COM -> SKP; SKP emits 8'h1C, K=1 for exactly SkpLen cycles, then returns to IDLE.
REQ-021 SkpPending decrements by 1 on the cycle COM is emitted; a simultaneous counter-wrap increment and decrement leaves it unchanged.
REQ-022 Insertion is never granted while in_packet=1; insertion waits for the InEop transfer, and the COM follows on the next cycle.
REQ-023 enable=0: InReady=0, counter and SkpPending hold, and an in-progress COM/SKP sequence completes before IDLE outputs logical idle.
REQ-024 A transfer with InEop=1 in the cycle a pending count becomes non-zero is followed directly by COM.

Reset
REQ-025 reset=1 SHALL asynchronously force state IDLE, TxData=8'h00, TxDataK=0, counter=0, SkpPending=0, in_packet=0, InReady=0.
REQ-026 Reset asserted mid-sequence SHALL abandon the COM/SKP sequence without completing it; after release, counting restarts at 0.

Configuration
REQ-027 With macro PIPE_SKP_STATS_EN defined, SHALL add output port SkpCount (16 bits), which increments on each COM emission, wraps 16'hFFFF->0, and resets to 0.
REQ-028 Without PIPE_SKP_STATS_EN, SHALL omit the SkpCount port and its logic; all other behaviour SHALL be identical.

Verification (SkpInterval=16, SkpLen=3)
REQ-029 Bench SHALL check: reset release, enable=1, InValid=0 -> 15 cycles of 00/K0, then BC/K1, then 1C/K1 x3; period 16 symbols.
REQ-030 Bench SHALL check: a 20-symbol packet starting cycle 10 -> InReady held 1 through its InEop, then COM immediately follows, with no SKP inside the packet.
REQ-031 Bench SHALL check: a packet spanning 40 cycles -> SkpPending reaches 2, then two back-to-back COM+3xSKP sequences after InEop, with SkpPending returning to 0.
REQ-032 Bench SHALL check: reset asserted on 2nd SKP symbol -> TxData=00/K0 immediately; after release, the first COM appears 16 cycles later.
REQ-033 Bench SHALL check: enable dropped for 50 cycles with pending=1 -> no COM and counter frozen; on re-enable, COM occurs next cycle.
REQ-034 With PIPE_SKP_STATS_EN, bench SHALL check: 5 insertions -> SkpCount=5; after reset, SkpCount=0.
